// File: rtl/dbg_probe_scanner.sv
// dbg_probe_scanner: round-robin debug display scanner over NCH probe words with dwell, hold/step, rewind and tagging
//   clk, rstn (async, active-low)       clock and reset
//   probe_i [NCH*DW]                    probe words, channel k at [k*DW +: DW]
//   en, hold, step, rewind              scan enable, freeze, single-step (rising edge under hold), return to channel 0
//   tag_en                              replace the top TAGW bits with channel number + 1
//   snap                                snapshot request (only with DBG_SNAPSHOT_EN)
//   data_o, ch_o, valid_o, wrap_o       display word, current channel, new-channel pulse, wrap pulse
// Optional build macro DBG_SNAPSHOT_EN: shadow bank so one sweep shows probe values from a single instant.
module dbg_probe_scanner #(
  parameter int NCH   = 8,
  parameter int DW    = 32,
  parameter int TAGW  = 4,
  parameter int DWELL = 33554432
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NCH*DW-1:0]       probe_i,
  input  logic                    en,
  input  logic                    hold,
  input  logic                    step,
  input  logic                    rewind,
  input  logic                    tag_en,
  input  logic                    snap,
  output logic [DW-1:0]           data_o,
  output logic [$clog2(NCH)-1:0]  ch_o,
  output logic                    valid_o,
  output logic                    wrap_o
);
  localparam int CW  = $clog2(NCH);
  localparam int DCW = DWELL > 1 ? $clog2(DWELL) : 1;
  logic [DCW-1:0]    dcnt, dcnt_n;
  logic [CW-1:0]     ch_n, ch_inc, dch;
  logic              step_q, step_edge, last, wrap_n, load;
  logic [NCH*DW-1:0] src;
  logic [DW-1:0]     w, word;
  always_comb begin
    step_edge = step & ~step_q;
    last      = ch_o == CW'(NCH - 1);
    ch_inc    = last ? '0 : ch_o + CW'(1);
    dcnt_n    = dcnt;
    ch_n      = ch_o;
    wrap_n    = 1'b0;
    if (rewind) begin
      dcnt_n = '0;
      ch_n   = '0;
    end else if (en && hold && step_edge) begin
      dcnt_n = '0;
      ch_n   = ch_inc;
      wrap_n = last;
    end else if (en && !hold) begin
      dcnt_n = dcnt == DCW'(DWELL - 1) ? '0 : dcnt + DCW'(1);
      ch_n   = dcnt == DCW'(DWELL - 1) ? ch_inc : ch_o;
      wrap_n = dcnt == DCW'(DWELL - 1) && last;
    end
  end
  // dch is the channel data_o currently shows; a mismatch forces one load even while frozen
  assign load = (en & ~hold) | (ch_o != dch);
  assign w    = src[int'(ch_o) * DW +: DW];
  assign word = tag_en ? {TAGW'(ch_o) + TAGW'(1), w[DW-TAGW-1:0]} : w;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dcnt    <= '0;
      ch_o    <= '0;
      dch     <= '0;
      step_q  <= 1'b0;
      data_o  <= '0;
      valid_o <= 1'b0;
      wrap_o  <= 1'b0;
    end else begin
      step_q  <= step;
      dcnt    <= dcnt_n;
      ch_o    <= ch_n;
      wrap_o  <= wrap_n;
      valid_o <= ch_o != dch;
      if (load) begin
        data_o <= word;
        dch    <= ch_o;
      end
    end
  end
`ifdef DBG_SNAPSHOT_EN
  logic [NCH*DW-1:0] bank;
  logic              snap_q, primed, cap;
  assign cap = en & (rewind | wrap_n | (snap & ~snap_q) | ~primed);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank   <= '0;
      snap_q <= 1'b0;
      primed <= 1'b0;
    end else begin
      snap_q <= snap;
      if (en) primed <= 1'b1;
      if (cap) bank <= probe_i;
    end
  end
  assign src = bank;
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign src = probe_i;
`endif
endmodule

// File: doc/dbg_probe_scanner.md
# dbg_probe_scanner

Parametrised debug-display scanner. It round-robins over `NCH` probe words from the CPU datapath (PC, register file, ALU, data memory, control signals), dwells a programmable number of cycles on each word, and optionally tags each word with its channel number. It supports freeze and single-step from the board switches. Its registered 32-bit output drives the seven-segment display driver and replaces the per-view ad-hoc counters in the CPU top level.

## Interface
Parameters:
- `NCH`, 8: number of probe channels, 2..16.
- `DW`, 32: probe and output word width.
- `TAGW`, 4: tag field width; must satisfy `2^TAGW > NCH`.
- `DWELL`, 33554432: cycles spent on each channel, ≥1.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: asynchronous, active-low reset.
- `probe_i` in `NCH*DW`: channel k occupies bits `[k*DW +: DW]`.
- `en` in 1: scan enable.
- `hold` in 1: freeze the scan and the displayed word.
- `step` in 1: level input; a rising edge advances one channel while `hold` is high.
- `rewind` in 1: synchronous return to channel 0.
- `tag_en` in 1: insert the channel tag into the top `TAGW` bits.
- `snap` in 1: snapshot request; has effect only with `DBG_SNAPSHOT_EN` defined.
- `data_o` out `DW`: registered display word.
- `ch_o` out `$clog2(NCH)`: current channel index.
- `valid_o` out 1: one-cycle pulse when `data_o` first shows a new channel.
- `wrap_o` out 1: one-cycle pulse when the channel index wraps from `NCH-1` to 0.

## Operation
- State: dwell counter `dcnt` (0..`DWELL-1`), channel index `ch`, registered `step_q` for edge detection, output register.
- Free-run: `en=1`, `hold=0`.
  - `dcnt` increments each cycle.
  - At `dcnt==DWELL-1`: `dcnt←0` and `ch←ch+1`, wrapping from `NCH-1` to 0.
- `hold=1`: `dcnt` and `ch` freeze, and `data_o` freezes.
  - A step edge (`step & ~step_q`) sets `ch←ch+1` with wrap, clears `dcnt`, and loads `data_o` once.
  - A step edge while `hold=0` is ignored.
- `en=0`: `dcnt`, `ch` and `data_o` are all frozen. Step edges are ignored. `rewind` is still honoured.
- Priority: `rewind` > `!en` > `hold` / step > dwell terminal.
  - `rewind` sets `ch←0` and `dcnt←0`, and reloads channel 0.
  - `wrap_o` does not pulse on `rewind`.
- Output word, live source `w = probe_i[ch]`:
  - `tag_en=1`: `data_o = {ch+1 (TAGW bits), w[DW-TAGW-1:0]}`. Tag values run 1..`NCH`.
  - `tag_en=0`: `data_o = w`.
- `data_o` is reloaded every cycle it is not frozen, so an unfrozen display tracks a live probe.
- `valid_o` is high for exactly the first cycle `data_o` reflects a channel index different from the previous one. This includes a step load, and a rewind from a nonzero channel.

## Timing
- Reset values: `data_o`, `ch_o`, `valid_o`, `wrap_o`, `dcnt`, `step_q` and the snapshot bank are all 0.
- Latency: a `probe_i` change appears on `data_o` 1 cycle later.
  - A channel advance at edge N shows the new channel's data and `valid_o` at edge N+1.
  - `ch_o` updates at edge N.
  - `wrap_o` asserts in the same cycle `ch_o` becomes 0.
- `DWELL=1`: the channel advances every cycle.
- Reset asserted mid-dwell clears the state immediately (asynchronous). After release, scanning restarts at channel 0 with a full dwell.
- `hold` asserted on the cycle of a dwell terminal: hold wins and no advance occurs.
- A step edge and `rewind` in the same cycle: rewind wins.

## Configuration
- `DBG_SNAPSHOT_EN` defined:
  - An `NCH*DW` shadow bank captures all of `probe_i` at once. Capture happens on the cycle `ch` becomes 0 (wrap or rewind), on a rising edge of `snap`, and on the first enabled cycle after reset.
  - `w` is taken from the shadow bank, so one full sweep shows values from a single instant.
  - Snapshot captures obey `en`, but not `hold`.
- `DBG_SNAPSHOT_EN` undefined:
  - There is no shadow bank, `w` is the live probe, and `snap` is ignored.

## Test plan
Common setup: `NCH=4`, `DWELL=3`, `probe_i` channel k = `32'h1000_0000+k`.

1. Reset release, `en=1`, `hold=0`, `tag_en=0`:
   - `ch_o` sequence 0,0,0,1,1,1,2,…; `data_o` lags `ch_o` by 1 cycle.
   - `wrap_o` pulses once per 12 cycles, when `ch_o` goes 3→0.
2. `tag_en=1` on channel 2 with probe `32'hABCD_EF12`:
   - `data_o = 32'h3BCD_EF12`.
3. `hold=1` on channel 1:
   - `ch_o` and `data_o` are stable for 20 cycles, even when probe 1 changes to `32'hDEAD_BEEF`.
   - A step pulse gives `ch_o=2`, `data_o=32'h1000_0002` and one `valid_o` pulse.
4. `rewind` on channel 3, simultaneous with a step edge during hold:
   - Next cycle `ch_o=0` and `data_o=32'h1000_0000`.
   - `valid_o` pulses once; `wrap_o` stays 0.
5. `rstn` low in mid-dwell on channel 2:
   - All outputs are 0 immediately.
   - After release the channel-0 dwell lasts exactly 3 cycles.
6. `DBG_SNAPSHOT_EN` build: change probe 2 to `32'h5555_5555` while `ch_o=1`.
   - Channel 2 still displays `32'h1000_0002`.
   - After a `snap` edge followed by `rewind`, channel 2 displays `32'h5555_5555`.
